regfile_onehot_wr: RTL
======================

// Module: regfile_onehot_wr
// PURPOSE
// - Register file that consumes the one-hot write-enable vector from the register-number decoder tree.
// - The tree is a 5:32 decoder built from 2:4 decoder stages and gated by the instruction's RegWrite.
// - Sits in the decode/writeback stage of the CPU: 1 write port, 2 combinational read ports.
// - Checks that the incoming enable vector really is one-hot.
// - Top register is hardwired zero (XZR).
// PARAMETERS
// - WIDTH  64  data bits per register
// - NREGS  32  number of registers; power of 2, >= 4; index NREGS-1 is the zero register
// - AW     $clog2(NREGS)  read-address width (localparam, not overridable)
// PORTS
// - clk        in   1         rising-edge clock
// - reset_n    in   1         asynchronous, active-low reset
// - wr_en_oh   in   NREGS     one-hot write enable from decoder tree; all-zero = no write
// - wr_data    in   WIDTH     write data
// - rd_addr_a  in   AW        read port A register number
// - rd_addr_b  in   AW        read port B register number
// - rd_data_a  out  WIDTH     read port A data
// - rd_data_b  out  WIDTH     read port B data
// - oh_err     out  1         sticky: a multi-hot wr_en_oh was seen
// - wr_count   out  16        count of committed writes (saturating)
// BEHAVIOUR
// - One clock (clk). Reset is asynchronous and active-low (reset_n).
// - Reset asserted, at any time including mid-write: immediately and without a clock
//   - all registers = 0
//   - oh_err = 0
//   - wr_count = 0
// - Reset deassertion is synchronised by the enclosing design, not by this block.
// - Write, at each rising clk edge when reset_n = 1:
//   - popcount(wr_en_oh) == 0: no change.
//   - popcount(wr_en_oh) == 1, bit i with i != NREGS-1: reg[i] <= wr_data; wr_count += 1, saturating at 16'hFFFF.
//   - popcount == 1, bit NREGS-1: no register change and no wr_count change (write to XZR is discarded).
//   - popcount >= 2: no register written; oh_err <= 1. oh_err stays set until reset.
// - Read: combinational, 0-cycle latency.
//   - rd_data_x = reg[rd_addr_x].
//   - rd_addr_x == NREGS-1 always returns 0.
// - Both read ports may address the same register; each returns the same value.
// - New write data is visible on a read port after the clock edge that commits it (1-cycle write-to-read latency), unless bypass is enabled.
// - Multi-hot detection is purely combinational on wr_en_oh ((v & (v-1)) != 0) and is registered only into oh_err.
// CONFIGURATION
// - REGFILE_BYPASS_EN defined: a read port returns wr_data combinationally when all of the following hold in the same cycle:
//   - wr_en_oh is exactly one-hot,
//   - it targets rd_addr_x,
//   - rd_addr_x != NREGS-1.
// - This gives write-then-read in the same cycle.
// - REGFILE_BYPASS_EN undefined: reads always return the stored value; the pipeline handles the hazard by stalling.
// STRUCTURE
// - regfile_pkg:
//   - REG_WIDTH = 64, REG_COUNT = 32, XZR_IDX = 31
//   - typedef logic [REG_WIDTH-1:0] reg_word_t
//   - typedef logic [$clog2(REG_COUNT)-1:0] reg_addr_t
// - Sub-module regfile_word: one WIDTH-bit register with enable and async active-low clear.
//   - Instantiated NREGS-1 times via generate; enable = wr_en_oh[i] & ~multi_hot.
// - Read muxes, bypass compare, error flag and counter are in the top module.
// TESTING
// - Reset: drive reset_n=0 mid-cycle with wr_en_oh=32'h1 -> rd_data_a/b = 0, oh_err = 0, wr_count = 0, with no clock edge needed.
// - Single write: wr_en_oh=32'h0000_0008, wr_data=64'hDEAD_BEEF_0123_4567; next cycle rd_addr_a=3 -> that value; wr_count = 1.
// - Write every reg 0..30 with value i*17, then read all pairs on A/B -> exact values; wr_count = 31.
// - Zero reg: wr_en_oh=32'h8000_0000, wr_data=all-ones -> rd_addr_a=31 reads 0; wr_count unchanged.
// - Multi-hot: wr_en_oh=32'h0000_0006, wr_data=64'h5 -> regs 1 and 2 unchanged; oh_err = 1 next cycle; still 1 after ten clean writes.
// - Bypass (REGFILE_BYPASS_EN defined): wr_en_oh=32'h10 and rd_addr_b=4 in the same cycle -> rd_data_b = wr_data before the edge. Undefined -> old value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the one-hot-write register file.
// Optional same-cycle write-to-read bypass is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int unsigned REG_WIDTH = 64;
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned XZR_IDX   = REG_COUNT - 1;

    typedef logic [REG_WIDTH-1:0]         reg_word_t;
    typedef logic [$clog2(REG_COUNT)-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_word.sv
// One storage word of the register file: load on enable, asynchronous
// active-low clear.
module regfile_word #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state: hold unless enabled.
    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    // Storage flop with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : regfile_word

// File: rtl/regfile_onehot_wr.sv
// Register file with a one-hot write-enable vector, two combinational read
// ports, a hardwired-zero top register, a sticky multi-hot error flag and a
// saturating committed-write counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_onehot_wr
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH = REG_WIDTH,
    parameter  int unsigned NREGS = REG_COUNT,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREGS-1:0] wr_en_oh,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             oh_err,
    output logic [15:0]      wr_count
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(NREGS - 1);

    logic             multi_hot;
    logic             one_hot;
    logic             commit;
    logic [WIDTH-1:0] regs [NREGS];

    logic             oh_err_d;
    logic             oh_err_q;
    logic [15:0]      wr_count_d;
    logic [15:0]      wr_count_q;

    // Enable-vector classification: multi-hot, exactly one-hot, real commit.
    always_comb begin
        multi_hot = |(wr_en_oh & (wr_en_oh - NREGS'(1)));
        one_hot   = (|wr_en_oh) & ~multi_hot;
        commit    = one_hot & ~wr_en_oh[NREGS-1];
    end

    // Storage words; the top index is the zero register and has no storage.
    for (genvar i = 0; i < NREGS - 1; i++) begin : g_word
        regfile_word #(.WIDTH(WIDTH)) u_word (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (wr_en_oh[i] & ~multi_hot),
            .d       (wr_data),
            .q       (regs[i])
        );
    end

    assign regs[NREGS-1] = '0;

    // Read muxes with optional same-cycle forwarding of write data.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (one_hot && wr_en_oh[rd_addr_a] && (rd_addr_a != ZERO_ADDR)) begin
            rd_data_a = wr_data;
        end
        if (one_hot && wr_en_oh[rd_addr_b] && (rd_addr_b != ZERO_ADDR)) begin
            rd_data_b = wr_data;
        end
`else
        if (rd_addr_a == ZERO_ADDR) begin
            rd_data_a = '0;
        end
        if (rd_addr_b == ZERO_ADDR) begin
            rd_data_b = '0;
        end
`endif
    end

    // Sticky error flag and saturating write counter next-state.
    always_comb begin
        oh_err_d   = oh_err_q | multi_hot;
        wr_count_d = wr_count_q;
        if (commit && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    // Status flops with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oh_err_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            oh_err_q   <= oh_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign oh_err   = oh_err_q;
    assign wr_count = wr_count_q;

endmodule : regfile_onehot_wr
